// File: rtl/aes128_round_engine.sv
// Iterative AES-128 encryption engine.
// One round datapath (SubBytes, ShiftRows, optional MixColumns, AddRoundKey) with
// on-the-fly key expansion, reused NUM_ROUNDS times behind a valid/ready handshake.
// CPR=2 splits each round into a registered SubBytes/ShiftRows stage and a
// MixColumns/AddRoundKey stage to shorten the critical path.
module aes128_round_engine #(
    parameter int NUM_ROUNDS = 10,
    parameter int CPR        = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] key,
    input  logic [127:0] data_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] data_out,
    output logic         busy,
    output logic [3:0]   round_idx
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);
    localparam bit         SPLIT      = (CPR == 2);

    // GF(2^8) multiply by x modulo the AES polynomial
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // GF(2^8) general multiply (shift-and-add)
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                p = p ^ aa;
            end else begin
                p = p;
            end
            aa = xtime(aa);
        end
        return p;
    endfunction

    // S-box computed as multiplicative inverse (x^254) followed by the affine map;
    // zero maps to zero under x^254, which is exactly what the S-box needs
    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [7:0] a;
        logic [7:0] inv;
        a = b;
        for (int i = 0; i < 6; i++) begin
            a = gf_mul(gf_mul(a, a), b);
        end
        inv = gf_mul(a, a);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    // SubBytes then ShiftRows on a column-major state (byte i = row i%4, column i/4)
    function automatic logic [127:0] sub_shift(input logic [127:0] s);
        logic [127:0] o;
        o = 128'h0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8*(r + 4*c) -: 8] = sbox(s[127 - 8*(r + 4*((c + r) % 4)) -: 8]);
            end
        end
        return o;
    endfunction

    // MixColumns over all four columns
    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = 128'h0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127 - 32*c -: 8];
            a1 = s[119 - 32*c -: 8];
            a2 = s[111 - 32*c -: 8];
            a3 = s[103 - 32*c -: 8];
            o[127 - 32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                                   a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                                   a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                                   xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
        end
        return o;
    endfunction

    // Round constant for rounds 1..10; anything else yields zero
    function automatic logic [7:0] rcon(input logic [3:0] idx);
        logic [7:0] rc;
        case (idx)
            4'd1:    rc = 8'h01;
            4'd2:    rc = 8'h02;
            4'd3:    rc = 8'h04;
            4'd4:    rc = 8'h08;
            4'd5:    rc = 8'h10;
            4'd6:    rc = 8'h20;
            4'd7:    rc = 8'h40;
            4'd8:    rc = 8'h80;
            4'd9:    rc = 8'h1b;
            4'd10:   rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

    // One step of the AES-128 key schedule
    function automatic logic [127:0] key_expand(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3, t, n0, n1, n2, n3;
        w0 = k[127:96];
        w1 = k[95:64];
        w2 = k[63:32];
        w3 = k[31:0];
        t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rc, 24'h000000};
        n0 = w0 ^ t;
        n1 = w1 ^ n0;
        n2 = w2 ^ n1;
        n3 = w3 ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    state_t       state_r, state_next_s;
    logic [127:0] data_r;
    logic [127:0] key_r;
    logic [127:0] sr_r;
    logic         phase_r;
    logic [3:0]   round_idx_r;
    logic         in_ready_r, busy_r, out_valid_r;
    logic [127:0] data_out_r;

    logic         accept_s, stage_step_s, round_step_s, retire_s, last_s;
    logic [127:0] key_next_s, round_in_s, mixed_s, round_out_s;

    assign in_ready  = in_ready_r;
    assign busy      = busy_r;
    assign out_valid = out_valid_r;
    assign data_out  = data_out_r;
    assign round_idx = round_idx_r;

    // Round datapath: next round key and the result of the current round
    always_comb begin
        last_s     = (round_idx_r == LAST_ROUND);
        key_next_s = key_expand(key_r, rcon(round_idx_r));
        if (SPLIT) begin
            round_in_s = sr_r;
        end else begin
            round_in_s = sub_shift(data_r);
        end
        if (last_s) begin
            mixed_s = round_in_s;
        end else begin
            mixed_s = mix_columns(round_in_s);
        end
        round_out_s = mixed_s ^ key_next_s;
    end

    // FSM next-state and step strobes
    always_comb begin
        state_next_s = state_r;
        accept_s     = 1'b0;
        stage_step_s = 1'b0;
        round_step_s = 1'b0;
        retire_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (in_valid) begin
                    accept_s     = 1'b1;
                    state_next_s = ST_ROUND;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ROUND: begin
                if (SPLIT && !phase_r) begin
                    stage_step_s = 1'b1;
                    state_next_s = ST_ROUND;
                end else begin
                    round_step_s = 1'b1;
                    if (last_s) begin
                        state_next_s = ST_DONE;
                    end else begin
                        state_next_s = ST_ROUND;
                    end
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    retire_s     = 1'b1;
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_DONE;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // FSM state register with registered handshake/status flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            in_ready_r <= 1'b1;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            in_ready_r <= (state_next_s == ST_IDLE);
            busy_r     <= (state_next_s == ST_ROUND);
        end
    end

    // Cipher state, round key, round counter and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_r      <= 128'h0;
            key_r       <= 128'h0;
            sr_r        <= 128'h0;
            phase_r     <= 1'b0;
            round_idx_r <= 4'd0;
            out_valid_r <= 1'b0;
            data_out_r  <= 128'h0;
        end else if (accept_s) begin
            data_r      <= data_in ^ key;
            key_r       <= key;
            round_idx_r <= 4'd1;
            phase_r     <= 1'b0;
        end else if (stage_step_s) begin
            sr_r    <= sub_shift(data_r);
            phase_r <= 1'b1;
        end else if (round_step_s) begin
            data_r  <= round_out_s;
            key_r   <= key_next_s;
            phase_r <= 1'b0;
            if (last_s) begin
                data_out_r  <= round_out_s;
                out_valid_r <= 1'b1;
            end else begin
                round_idx_r <= round_idx_r + 4'd1;
            end
        end else if (retire_s) begin
            out_valid_r <= 1'b0;
            round_idx_r <= 4'd0;
        end else begin
            phase_r <= phase_r;
        end
    end

endmodule

// File: tb/tb_aes128_round_engine.sv
// Directed bench for aes128_round_engine: FIPS-197 vectors, latency, round
// counter, backpressure, back-to-back blocks, mid-operation reset, CPR=2 and
// NUM_ROUNDS=1 variants.
module tb_aes128_round_engine;

    localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
    // One final round on zero key/state: 63 bytes xor first round key 62636363...
    localparam logic [127:0] CT_R1  = 128'h01000000010000000100000001000000;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int n_cmp = 0;
    int n_bad = 0;

    // DUT A: 10 rounds, 1 cycle per round
    logic         a_in_valid = 1'b0, a_in_ready, a_out_valid, a_out_ready = 1'b0, a_busy;
    logic [127:0] a_key = 128'h0, a_data_in = 128'h0, a_data_out;
    logic [3:0]   a_round_idx;
    // DUT B: 10 rounds, 2 cycles per round
    logic         b_in_valid = 1'b0, b_in_ready, b_out_valid, b_out_ready = 1'b0, b_busy;
    logic [127:0] b_key = 128'h0, b_data_in = 128'h0, b_data_out;
    logic [3:0]   b_round_idx;
    // DUT C: single round
    logic         c_in_valid = 1'b0, c_in_ready, c_out_valid, c_out_ready = 1'b0, c_busy;
    logic [127:0] c_key = 128'h0, c_data_in = 128'h0, c_data_out;
    logic [3:0]   c_round_idx;

    always #5 clk = ~clk;

    aes128_round_engine #(.NUM_ROUNDS(10), .CPR(1)) dut_a (
        .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .key(a_key), .data_in(a_data_in), .out_valid(a_out_valid),
        .out_ready(a_out_ready), .data_out(a_data_out), .busy(a_busy),
        .round_idx(a_round_idx));

    aes128_round_engine #(.NUM_ROUNDS(10), .CPR(2)) dut_b (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .key(b_key), .data_in(b_data_in), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .data_out(b_data_out), .busy(b_busy),
        .round_idx(b_round_idx));

    aes128_round_engine #(.NUM_ROUNDS(1), .CPR(1)) dut_c (
        .clk(clk), .rst(rst), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .key(c_key), .data_in(c_data_in), .out_valid(c_out_valid),
        .out_ready(c_out_ready), .data_out(c_data_out), .busy(c_busy),
        .round_idx(c_round_idx));

    // Present one block to DUT A for exactly one accepting edge; returns #1 after it
    task automatic start_a(input logic [127:0] k, input logic [127:0] pt);
        @(negedge clk);
        a_key      = k;
        a_data_in  = pt;
        a_in_valid = 1'b1;
        @(posedge clk);
        #1;
        a_in_valid = 1'b0;
    endtask

    // Count edges until DUT A raises out_valid; lat=-1 if the budget runs out
    task automatic wait_a(output int lat, output logic [127:0] res);
        lat = -1;
        res = 128'h0;
        for (int n = 1; n <= 60; n++) begin
            @(posedge clk);
            #1;
            if (a_out_valid === 1'b1) begin
                lat = n;
                res = a_data_out;
                break;
            end
        end
    endtask

    // Retire the DUT A output with a one-cycle out_ready pulse
    task automatic retire_a();
        a_out_ready = 1'b1;
        @(posedge clk);
        #1;
        a_out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (a_in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b expected 1", a_in_ready); end
        n_cmp++; if (a_out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b expected 0", a_out_valid); end
        n_cmp++; if (a_busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b expected 0", a_busy); end
        n_cmp++; if (a_round_idx !== 4'd0) begin n_bad++; $display("FAIL reset_round_idx: got %0d expected 0", a_round_idx); end
        n_cmp++; if (a_data_out !== 128'h0) begin n_bad++; $display("FAIL reset_data_out: got %h expected 0", a_data_out); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_fips_c1();
        int lat;
        logic [127:0] res;
        start_a(KEY_C1, PT_C1);
        n_cmp++; if (a_busy !== 1'b1 || a_in_ready !== 1'b0) begin n_bad++; $display("FAIL c1_busy: got busy=%b in_ready=%b expected 1/0", a_busy, a_in_ready); end
        wait_a(lat, res);
        n_cmp++; if (lat !== 10) begin n_bad++; $display("FAIL c1_latency: got %0d expected 10", lat); end
        n_cmp++; if (res !== CT_C1) begin n_bad++; $display("FAIL c1_data: got %h expected %h", res, CT_C1); end
        retire_a();
        n_cmp++; if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1 || a_round_idx !== 4'd0) begin
            n_bad++; $display("FAIL c1_retire: got ov=%b ir=%b ri=%0d expected 0/1/0", a_out_valid, a_in_ready, a_round_idx); end
    endtask

    task automatic test_fips_b_round_idx();
        start_a(KEY_B, PT_B);
        n_cmp++; if (a_round_idx !== 4'd1) begin n_bad++; $display("FAIL b_round_idx_1: got %0d expected 1", a_round_idx); end
        for (int k = 1; k <= 9; k++) begin
            @(posedge clk);
            #1;
            n_cmp++; if (a_round_idx !== 4'(k + 1) || a_out_valid !== 1'b0) begin
                n_bad++; $display("FAIL b_round_idx_step: got %0d ov=%b expected %0d ov=0", a_round_idx, a_out_valid, k + 1); end
        end
        @(posedge clk);
        #1;
        n_cmp++; if (a_out_valid !== 1'b1 || a_round_idx !== 4'd10) begin
            n_bad++; $display("FAIL b_done: got ov=%b ri=%0d expected 1/10", a_out_valid, a_round_idx); end
        n_cmp++; if (a_data_out !== CT_B) begin n_bad++; $display("FAIL b_data: got %h expected %h", a_data_out, CT_B); end
        retire_a();
    endtask

    task automatic test_backpressure();
        int lat;
        logic [127:0] res;
        start_a(KEY_C1, PT_C1);
        wait_a(lat, res);
        n_cmp++; if (res !== CT_C1) begin n_bad++; $display("FAIL bp_first: got %h expected %h", res, CT_C1); end
        for (int i = 0; i < 20; i++) begin
            if (i == 5) begin
                a_key      = KEY_B;
                a_data_in  = PT_B;
                a_in_valid = 1'b1;
            end
            @(posedge clk);
            #1;
            n_cmp++; if (a_out_valid !== 1'b1 || a_data_out !== CT_C1 || a_in_ready !== 1'b0) begin
                n_bad++; $display("FAIL bp_hold: got ov=%b ir=%b data=%h expected 1/0 %h", a_out_valid, a_in_ready, a_data_out, CT_C1); end
        end
        // Retire with in_valid still high: must not accept on the same edge
        retire_a();
        n_cmp++; if (a_out_valid !== 1'b0 || a_busy !== 1'b0 || a_in_ready !== 1'b1) begin
            n_bad++; $display("FAIL bp_release: got ov=%b busy=%b ir=%b expected 0/0/1", a_out_valid, a_busy, a_in_ready); end
        @(posedge clk);
        #1;
        a_in_valid = 1'b0;
        n_cmp++; if (a_busy !== 1'b1 || a_round_idx !== 4'd1) begin
            n_bad++; $display("FAIL bp_accept: got busy=%b ri=%0d expected 1/1", a_busy, a_round_idx); end
        wait_a(lat, res);
        n_cmp++; if (lat !== 10 || res !== CT_B) begin
            n_bad++; $display("FAIL bp_second: got lat=%0d data=%h expected 10 %h", lat, res, CT_B); end
        retire_a();
    endtask

    task automatic test_back_to_back();
        int lat;
        logic [127:0] res;
        @(negedge clk);
        a_out_ready = 1'b1;
        a_key       = KEY_B;
        a_data_in   = PT_B;
        a_in_valid  = 1'b1;
        @(posedge clk);
        #1;
        a_key     = KEY_C1;
        a_data_in = PT_C1;
        wait_a(lat, res);
        n_cmp++; if (lat !== 10 || res !== CT_B) begin
            n_bad++; $display("FAIL b2b_first: got lat=%0d data=%h expected 10 %h", lat, res, CT_B); end
        wait_a(lat, res);
        a_in_valid = 1'b0;
        n_cmp++; if (lat !== 12 || res !== CT_C1) begin
            n_bad++; $display("FAIL b2b_second: got gap=%0d data=%h expected 12 %h", lat, res, CT_C1); end
        @(posedge clk);
        #1;
        a_out_ready = 1'b0;
        n_cmp++; if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin
            n_bad++; $display("FAIL b2b_retire: got ov=%b ir=%b expected 0/1", a_out_valid, a_in_ready); end
    endtask

    task automatic test_reset_mid();
        int lat;
        logic [127:0] res;
        start_a(KEY_C1, PT_C1);
        repeat (4) @(posedge clk);
        #1;
        n_cmp++; if (a_round_idx !== 4'd5) begin n_bad++; $display("FAIL mid_round5: got %0d expected 5", a_round_idx); end
        #2;
        rst = 1'b1;
        #1;
        n_cmp++; if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1 || a_round_idx !== 4'd0 || a_busy !== 1'b0) begin
            n_bad++; $display("FAIL mid_reset: got ov=%b ir=%b ri=%0d busy=%b expected 0/1/0/0", a_out_valid, a_in_ready, a_round_idx, a_busy); end
        @(negedge clk);
        rst = 1'b0;
        start_a(KEY_C1, PT_C1);
        wait_a(lat, res);
        n_cmp++; if (lat !== 10 || res !== CT_C1) begin
            n_bad++; $display("FAIL mid_fresh: got lat=%0d data=%h expected 10 %h", lat, res, CT_C1); end
        retire_a();
    endtask

    task automatic test_cpr2();
        int lat;
        lat = -1;
        @(negedge clk);
        b_key      = KEY_C1;
        b_data_in  = PT_C1;
        b_in_valid = 1'b1;
        @(posedge clk);
        #1;
        b_in_valid = 1'b0;
        for (int n = 1; n <= 60; n++) begin
            @(posedge clk);
            #1;
            if (b_out_valid === 1'b1) begin
                lat = n;
                break;
            end
        end
        n_cmp++; if (lat !== 20) begin n_bad++; $display("FAIL cpr2_latency: got %0d expected 20", lat); end
        n_cmp++; if (b_data_out !== CT_C1) begin n_bad++; $display("FAIL cpr2_data: got %h expected %h", b_data_out, CT_C1); end
        b_out_ready = 1'b1;
        @(posedge clk);
        #1;
        b_out_ready = 1'b0;
        n_cmp++; if (b_out_valid !== 1'b0 || b_in_ready !== 1'b1) begin
            n_bad++; $display("FAIL cpr2_retire: got ov=%b ir=%b expected 0/1", b_out_valid, b_in_ready); end
    endtask

    task automatic test_single_round();
        @(negedge clk);
        c_key      = 128'h0;
        c_data_in  = 128'h0;
        c_in_valid = 1'b1;
        @(posedge clk);
        #1;
        c_in_valid = 1'b0;
        n_cmp++; if (c_round_idx !== 4'd1 || c_out_valid !== 1'b0) begin
            n_bad++; $display("FAIL r1_start: got ri=%0d ov=%b expected 1/0", c_round_idx, c_out_valid); end
        @(posedge clk);
        #1;
        n_cmp++; if (c_out_valid !== 1'b1 || c_data_out !== CT_R1) begin
            n_bad++; $display("FAIL r1_data: got ov=%b data=%h expected 1 %h", c_out_valid, c_data_out, CT_R1); end
        c_out_ready = 1'b1;
        @(posedge clk);
        #1;
        c_out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fips_c1();
        test_fips_b_round_idx();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_cpr2();
        test_single_round();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
